// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
// dbg_pkg : run-control state encoding and default widths for debug_controller
// Rev 1.0 : initial release
// ============================================================================
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2,
    ST_ACCESS = 2'd3
  } dbg_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 4;
  localparam int DEF_PC_W   = 10;
  localparam int DEF_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/dbg_cmd_port.sv
`default_nettype none
// ============================================================================
// dbg_cmd_port : debug register-command latch and one-cycle response register
// Rev 1.0 : initial release
// ============================================================================
module dbg_cmd_port
  import dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              access,
  input  logic              cmd_we,
  input  logic [REG_AW-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] rf_dbg_rdata,
  output logic              rf_dbg_sel,
  output logic              rf_dbg_we,
  output logic [REG_AW-1:0] rf_dbg_addr,
  output logic [DATA_W-1:0] rf_dbg_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  logic              we_q, we_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = access;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      we_d    = cmd_we;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
    end
    if (access) begin
      rsp_data_d = we_q ? '0 : rf_dbg_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // The strobe is qualified by reset so an aborted access never lands in the bank.
  assign rf_dbg_sel   = access;
  assign rf_dbg_we    = access & we_q & reset;
  assign rf_dbg_addr  = addr_q;
  assign rf_dbg_wdata = wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule
`default_nettype wire

// File: rtl/debug_controller.sv
`default_nettype none
// ============================================================================
// debug_controller : CPU run-control (halt/run/step/breakpoint) and debug
//                    register-bank access sequencer
// Rev 1.0 : initial release
// ============================================================================
module debug_controller
  import dbg_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_AW       = DEF_REG_AW,
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt_req,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic              cpu_en,
  output logic              halted,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [REG_AW-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rf_dbg_sel,
  output logic              rf_dbg_we,
  output logic [REG_AW-1:0] rf_dbg_addr,
  output logic [DATA_W-1:0] rf_dbg_wdata,
  input  logic [DATA_W-1:0] rf_dbg_rdata,
  output logic [CNT_W-1:0]  instr_count
);

  dbg_state_e       state_q, state_d;
  logic             resumed_q, resumed_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             bp_hit;

  always_comb begin
    state_d   = state_q;
    resumed_d = 1'b0;
    cpu_en    = 1'b0;
    halted    = 1'b0;
    cmd_ready = 1'b0;
    // resumed_q masks the breakpoint for the first instruction after a resume
    bp_hit    = (state_q == ST_RUN) && bp_en && (cpu_pc == bp_addr) && !resumed_q;
    case (state_q)
      ST_RUN: begin
        cpu_en = !bp_hit;
        if (halt_req || bp_hit) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (!halt_req) begin
          if (step_req) begin
            state_d = ST_STEP;
          end else if (run_req) begin
            state_d   = ST_RUN;
            resumed_d = 1'b1;
          end else if (cmd_valid) begin
            cmd_ready = 1'b1;
            state_d   = ST_ACCESS;
          end
        end
      end
      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALTED;
      end
      ST_ACCESS: begin
        halted  = 1'b1;
        state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
    instr_count_d = instr_count_q + CNT_W'(cpu_en);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (RESET_HALTED) state_q <= ST_HALTED;
      else              state_q <= ST_RUN;
      resumed_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      resumed_q     <= resumed_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;

  dbg_cmd_port #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_cmd_port (
    .clk          (clk),
    .reset        (reset),
    .accept       (cmd_ready),
    .access       (state_q == ST_ACCESS),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rf_dbg_rdata (rf_dbg_rdata),
    .rf_dbg_sel   (rf_dbg_sel),
    .rf_dbg_we    (rf_dbg_we),
    .rf_dbg_addr  (rf_dbg_addr),
    .rf_dbg_wdata (rf_dbg_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_controller.sv
`default_nettype none
// ============================================================================
// tb_debug_controller : directed + randomized bench against a behavioural model
// Rev 1.0 : initial release
// ============================================================================
module tb_debug_controller;

  localparam int M_FREE = 0, M_STOPPED = 1, M_ONESHOT = 2, M_BUSY = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       halt_req, run_req, step_req, bp_en;
  logic [9:0] bp_addr, cpu_pc;
  logic       cpu_en, halted;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rf_dbg_sel, rf_dbg_we;
  logic [3:0] rf_dbg_addr;
  logic [7:0] rf_dbg_wdata, rf_dbg_rdata;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  debug_controller dut (
    .clk          (clk),
    .reset        (reset),
    .halt_req     (halt_req),
    .run_req      (run_req),
    .step_req     (step_req),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .cpu_pc       (cpu_pc),
    .cpu_en       (cpu_en),
    .halted       (halted),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rf_dbg_sel   (rf_dbg_sel),
    .rf_dbg_we    (rf_dbg_we),
    .rf_dbg_addr  (rf_dbg_addr),
    .rf_dbg_wdata (rf_dbg_wdata),
    .rf_dbg_rdata (rf_dbg_rdata),
    .instr_count  (instr_count)
  );

  // Register bank stand-in: R0 reads zero and ignores writes.
  logic [7:0] bank [16] = '{default: 8'h00};
  assign rf_dbg_rdata = (rf_dbg_addr == 4'd0) ? 8'h00 : bank[rf_dbg_addr];
  always @(posedge clk) if (rf_dbg_we && rf_dbg_addr != 4'd0) bank[rf_dbg_addr] <= rf_dbg_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_* describes the controller after the coming edge.
  int         m_mode = M_FREE;
  bit         m_resumed = 1'b0, m_rsp_pend = 1'b0, m_we = 1'b0;
  logic [7:0] m_rsp_data = 8'h00, m_wdata = 8'h00;
  logic [3:0] m_addr = 4'd0;
  logic [15:0] m_count = 16'd0;
  logic [9:0] m_pc = 10'd0;
  logic [7:0] m_regs [16] = '{default: 8'h00};

  always @(negedge clk) begin
    bit bp, e_en, e_halt, e_rdy, busy;
    busy   = (m_mode == M_BUSY);
    bp     = (m_mode == M_FREE) && bp_en && (cpu_pc == bp_addr) && !m_resumed;
    e_en   = ((m_mode == M_FREE) && !bp) || (m_mode == M_ONESHOT);
    e_halt = (m_mode == M_STOPPED) || busy;
    e_rdy  = (m_mode == M_STOPPED) && !halt_req && !step_req && !run_req && cmd_valid;
    if (chk_on) begin
      chk("cpu_en", cpu_en, e_en);
      chk("halted", halted, e_halt);
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("rf_dbg_sel", rf_dbg_sel, busy);
      chk("rf_dbg_we", rf_dbg_we, busy && m_we && reset);
      if (busy) chk("rf_dbg_addr", rf_dbg_addr, m_addr);
      if (busy && m_we) chk("rf_dbg_wdata", rf_dbg_wdata, m_wdata);
      chk("rsp_valid", rsp_valid, m_rsp_pend);
      if (m_rsp_pend) chk("rsp_data", rsp_data, m_rsp_data);
      chk("instr_count", instr_count, m_count);
    end
    if (!reset) begin
      m_mode = M_FREE; m_count = 16'd0; m_rsp_pend = 1'b0; m_resumed = 1'b0;
      m_pc = 10'd0; m_we = 1'b0; m_addr = 4'd0; m_wdata = 8'h00;
    end else begin
      m_count = m_count + 16'(e_en);
      if (e_en) m_pc = (m_pc + 10'd1) & 10'h00F;
      m_rsp_pend = busy;
      if (busy) begin
        m_rsp_data = m_we ? 8'h00 : m_regs[m_addr];
        if (m_we && m_addr != 4'd0) m_regs[m_addr] = m_wdata;
      end
      m_resumed = 1'b0;
      case (m_mode)
        M_FREE: if (halt_req || bp) m_mode = M_STOPPED;
        M_STOPPED: begin
          if (halt_req) m_mode = M_STOPPED;
          else if (step_req) m_mode = M_ONESHOT;
          else if (run_req) begin m_mode = M_FREE; m_resumed = 1'b1; end
          else if (cmd_valid) begin
            m_mode = M_BUSY; m_we = cmd_we; m_addr = cmd_addr; m_wdata = cmd_wdata;
          end
        end
        default: m_mode = M_STOPPED;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cpu_pc = m_pc;
  endtask

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
  endtask

  initial begin
    bit found;
    reset = 1'b0; halt_req = 0; run_req = 0; step_req = 0; bp_en = 0;
    bp_addr = '0; cpu_pc = '0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) tick();
    reset = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_cpu_en", cpu_en, 1); chk("rst_halted", halted, 0); chk("rst_count", instr_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_sel", rf_dbg_sel, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(); @(negedge clk); chk("count_seq", instr_count, i);
    end
    // halt request at count 5: that instruction still retires
    tick(); tick(); halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    @(negedge clk);
    chk("halt_count", instr_count, 6); chk("halt_cpu_en", cpu_en, 0); chk("halt_halted", halted, 1);
    repeat (10) tick();
    @(negedge clk); chk("halt_hold", instr_count, 6);
    // register write then reads of R3 and R0
    tick(); send(1'b1, 4'd3, 8'hA5);
    @(negedge clk); chk("wr_ready", cmd_ready, 1);
    tick(); cmd_valid = 1'b0;
    @(negedge clk);
    chk("wr_we", rf_dbg_we, 1); chk("wr_addr", rf_dbg_addr, 3); chk("wr_data", rf_dbg_wdata, 8'hA5);
    tick(); send(1'b0, 4'd3, 8'h00);
    @(negedge clk);
    chk("wr_rsp", rsp_valid, 1); chk("wr_rsp_data", rsp_data, 0); chk("rd_ready", cmd_ready, 1);
    tick(); cmd_valid = 1'b0;
    @(negedge clk); chk("rd_we", rf_dbg_we, 0);
    tick(); send(1'b0, 4'd0, 8'h00);
    @(negedge clk); chk("rd_rsp", rsp_valid, 1); chk("rd_r3", rsp_data, 8'hA5);
    tick(); cmd_valid = 1'b0;
    tick();
    @(negedge clk); chk("rd_r0_rsp", rsp_valid, 1); chk("rd_r0", rsp_data, 8'h00);
    // step held for three cycles
    tick(); step_req = 1'b1;
    @(negedge clk); chk("step_start", instr_count, 6);
    tick(); tick(); tick(); step_req = 1'b0;
    @(negedge clk); chk("step_en", cpu_en, 1);
    tick();
    @(negedge clk); chk("step_count", instr_count, 8); chk("step_halted", halted, 1);
    // resume, then a command while running must not be accepted
    tick(); run_req = 1'b1;
    tick(); run_req = 1'b0; send(1'b1, 4'd7, 8'h11);
    @(negedge clk); chk("run_no_ready", cmd_ready, 0);
    tick(); cmd_valid = 1'b0;
    tick(); tick(); bp_en = 1'b1; bp_addr = 10'h004;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cpu_pc == 10'h004) found = 1'b1;
      else tick();
    end
    chk("bp_reached", found, 1);
    chk("bp_cpu_en", cpu_en, 0);
    tick(); run_req = 1'b1;
    @(negedge clk); chk("bp_halted", halted, 1);
    tick(); run_req = 1'b0;
    @(negedge clk); chk("bp_resume_en", cpu_en, 1); chk("bp_resume_pc", cpu_pc, 10'h004);
    tick();
    @(negedge clk); chk("bp_past_halted", halted, 0); chk("bp_past_en", cpu_en, 1);
    bp_en = 1'b0;
    // reset during a write access
    tick(); halt_req = 1'b1;
    tick(); halt_req = 1'b0; send(1'b1, 4'd5, 8'h3C);
    @(negedge clk); chk("abort_ready", cmd_ready, 1);
    tick(); cmd_valid = 1'b0; reset = 1'b0;
    @(negedge clk); chk("abort_we", rf_dbg_we, 0);
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp", rsp_valid, 0); chk("abort_run", halted, 0);
    chk("abort_en", cpu_en, 1); chk("abort_count", instr_count, 0); chk("abort_bank", bank[5], 8'h00);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset     = ($urandom_range(0, 199) != 0);
      halt_req  = ($urandom_range(0, 19) == 0);
      run_req   = ($urandom_range(0, 9) == 0);
      step_req  = ($urandom_range(0, 9) == 0);
      cmd_valid = ($urandom_range(0, 4) < 2);
      cmd_we    = 1'($urandom_range(0, 1));
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_wdata = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = 10'($urandom_range(0, 15));
      end
    end
    tick(); reset = 1'b1; halt_req = 0; run_req = 0; step_req = 0; cmd_valid = 0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
